mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width (unsigned).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, operand memory address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 6, width of the vector-length field.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+LEN_WIDTH, accumulator/result width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request a new vector operation.
REQ-008 SHALL have port mode, input, 2, 0 CLEAR, 1 MULT (acc+=a*b), 2 ADD (acc+=a+b), 3 SUM0 (acc+=a).
REQ-009 SHALL have port vec_len, input, LEN_WIDTH, number of element pairs.
REQ-010 SHALL have ports base_0 and base_1, input, ADDR_WIDTH each, start addresses of operand memories 0 and 1.
REQ-011 SHALL have port mem_en, output, 1, read enable shared by both synchronous-read memories.
REQ-012 SHALL have ports addr_0 and addr_1, output, ADDR_WIDTH each, memory read addresses.
REQ-013 SHALL have ports rd_data_0 and rd_data_1, input, DATA_WIDTH each, memory data, valid one cycle after mem_en.
REQ-014 SHALL have port busy, output, 1, high from start acceptance until result handshake.
REQ-015 SHALL have port res_valid, output, 1; port res_ready, input, 1; port result, output, ACC_WIDTH; port ovf, output, 1, sticky overflow.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL accept start only in IDLE; on acceptance latch mode, vec_len, base_0, base_1, clear accumulator and ovf, set busy.
REQ-018 SHALL ignore start in RUN, DRAIN and DONE, without side effects.
REQ-019 SHALL, in RUN, assert mem_en for exactly vec_len consecutive cycles with addr_x = base_x + idx (idx 0..vec_len-1), wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL accumulate each rd_data pair on the cycle after its mem_en cycle, through a one-cycle valid pipe.
REQ-021 SHALL enter DRAIN after the last RUN cycle, then DONE; res_valid rises exactly vec_len+2 edges after the edge that accepted start.
REQ-022 SHALL treat mode CLEAR or vec_len==0 as zero-length: no mem_en, result 0, res_valid two edges after acceptance.
REQ-023 SHALL hold result, ovf and res_valid stable in DONE until res_ready is high; then go to IDLE, dropping res_valid and busy on the next edge.
REQ-024 SHALL compute all arithmetic unsigned: products 2*DATA_WIDTH bits, sums zero-extended to ACC_WIDTH.
REQ-025 SHALL set ovf when any accumulation carries beyond ACC_WIDTH; ovf stays set until the next accepted start.
REQ-026 SHALL drive mem_en low and hold addr_0/addr_1 at their last value outside RUN.

Reset
REQ-027 SHALL, with rst high at an edge, enter IDLE and force mem_en, busy, res_valid, ovf, result, addr_0 and addr_1 to 0, regardless of state; an operation in progress is discarded.
REQ-028 SHALL give rst priority over start and res_ready on the same edge.

Configuration
REQ-029 SHALL, with macro MAC_SEQ_SAT_EN defined, clamp the accumulator at 2^ACC_WIDTH-1 on overflow; without it, wrap modulo 2^ACC_WIDTH. ovf behaves the same in both cases.

Structure
REQ-030 SHALL place mode encodings and FSM state encodings in shared package mac_seq_pkg.
REQ-031 SHALL implement the accumulator (operand select, add, overflow, saturation) as sub-module mac_seq_acc; the FSM and address generation stay in mac_seq_ctrl.

Verification
REQ-032 Mode ADD, vec_len=9, mem0={3,1,2,6,0,5,0,0,3}, mem1 all 0 -> result=20, res_valid at edge 11, ovf=0.
REQ-033 Mode MULT, same mem0, mem1 all 0 -> result=0; then mem1 all 1 -> result=20.
REQ-034 base_0=14, vec_len=4 -> addr_0 sequence 14,15,0,1 (wrap-around); result matches sum of those words.
REQ-035 ACC_WIDTH=4, mode SUM0, four words of 15 -> ovf=1; result 15 with MAC_SEQ_SAT_EN defined, 12 without.
REQ-036 rst pulsed mid-RUN -> next edge: IDLE, all outputs 0; start on the same edge as rst is ignored.
REQ-037 res_ready held low 5 cycles in DONE, with start pulsed -> result held stable, start ignored; res_ready=1 -> IDLE next edge.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared mode and FSM state encodings for the vector MAC sequencer.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_MULT  = 2'd1,
    MODE_ADD   = 2'd2,
    MODE_SUM0  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_seq_acc.sv
// Accumulator for mac_seq_ctrl: operand select, unsigned add, sticky overflow.
// Define MAC_SEQ_SAT_EN to clamp at all-ones on overflow instead of wrapping.
module mac_seq_acc
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ACC_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  mode_e                 mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  // One spare bit above the wider of accumulator and product holds the carry.
  localparam int unsigned EXT_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
  localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_WIDTH{1'b1}});

  logic [EXT_W-1:0] term;
  logic [EXT_W-1:0] sum;
  logic             carry;

  always_comb begin
    term = '0;
    case (mode)
      MODE_MULT: term = EXT_W'(a) * EXT_W'(b);
      MODE_ADD:  term = EXT_W'(a) + EXT_W'(b);
      MODE_SUM0: term = EXT_W'(a);
      default:   term = '0;
    endcase
    sum   = EXT_W'(acc) + term;
    carry = (sum > ACC_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (carry) begin
        ovf <= 1'b1;
`ifdef MAC_SEQ_SAT_EN
        acc <= '1;
`else
        acc <= sum[ACC_WIDTH-1:0];
`endif
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Vector MAC sequencer: walks two synchronous-read operand memories and accumulates.
// Optional MAC_SEQ_SAT_EN selects a saturating accumulator in mac_seq_acc.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [ADDR_WIDTH-1:0] base_0,
  input  logic [ADDR_WIDTH-1:0] base_1,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] addr_0,
  output logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] rd_data_0,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  ovf
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  drain_q;
  logic                  pipe_v_q;
  logic                  accept_c;
  logic                  zero_len_c;
  logic                  mem_en_d, busy_d, res_valid_d;
  logic [ADDR_WIDTH-1:0] addr_0_d, addr_1_d;
  logic [ACC_WIDTH-1:0]  result_d;
  logic [ACC_WIDTH-1:0]  acc;

  assign accept_c   = (state_q == IDLE) && start;
  assign zero_len_c = (mode_e'(mode) == MODE_CLEAR) || (vec_len == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DRAIN always lasts two cycles so results land vec_len+2 edges after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_len_c ? DRAIN : RUN;
      RUN:     if (cnt_q == len_q) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts memory reads issued so far, including the current one.
  always_comb begin
    mem_en_d    = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_0_d    = addr_0;
    addr_1_d    = addr_1;
    result_d    = result;
    if (accept_c) begin
      mode_d = mode_e'(mode);
      len_d  = vec_len;
      cnt_d  = LEN_WIDTH'(1);
      if (state_d == RUN) begin
        addr_0_d = base_0;
        addr_1_d = base_1;
      end
    end else if (state_q == RUN && state_d == RUN) begin
      cnt_d    = cnt_q + LEN_WIDTH'(1);
      addr_0_d = addr_0 + ADDR_WIDTH'(1);
      addr_1_d = addr_1 + ADDR_WIDTH'(1);
    end
    if (state_q == DRAIN && state_d == DONE) result_d = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_CLEAR;
      len_q     <= '0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      pipe_v_q  <= 1'b0;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      addr_0    <= '0;
      addr_1    <= '0;
      result    <= '0;
    end else begin
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      drain_q   <= (state_q == DRAIN);
      pipe_v_q  <= mem_en;
      mem_en    <= mem_en_d;
      busy      <= busy_d;
      res_valid <= res_valid_d;
      addr_0    <= addr_0_d;
      addr_1    <= addr_1_d;
      result    <= result_d;
    end
  end

  mac_seq_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_c),
    .en   (pipe_v_q),
    .mode (mode_q),
    .a    (rd_data_0),
    .b    (rd_data_1),
    .acc  (acc),
    .ovf  (ovf)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl; a second ACC_WIDTH=4 instance runs in lockstep.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, res_ready;
  logic [1:0]  mode;
  logic [5:0]  vec_len;
  logic [3:0]  base_0, base_1;
  logic        mem_en, busy, res_valid, ovf;
  logic [3:0]  addr_0, addr_1;
  logic [3:0]  rd_data_0 = '0, rd_data_1 = '0;
  logic [13:0] result;
  logic        s_mem_en, s_busy, s_res_valid, s_ovf;
  logic [3:0]  s_addr_0, s_addr_1, s_result;

  logic [3:0]  mem0 [16];
  logic [3:0]  mem1 [16];
  int          addr_log [$];
  int          checks = 0;
  int          errors = 0;
  int          lat, en_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      rd_data_0 <= mem0[addr_0];
      rd_data_1 <= mem1[addr_1];
    end
  end

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_len(vec_len),
    .base_0(base_0), .base_1(base_1), .mem_en(mem_en), .addr_0(addr_0), .addr_1(addr_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .ovf(ovf)
  );

  mac_seq_ctrl #(.ACC_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_len(vec_len),
    .base_0(base_0), .base_1(base_1), .mem_en(s_mem_en), .addr_0(s_addr_0), .addr_1(s_addr_1),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .busy(s_busy), .res_valid(s_res_valid),
    .res_ready(res_ready), .result(s_result), .ovf(s_ovf)
  );

  // Issue one operation and wait (bounded) for res_valid; lat=-1 on timeout.
  task automatic run_op(input logic [1:0] m, input logic [5:0] len,
                        input logic [3:0] b0, input logic [3:0] b1);
    addr_log.delete();
    @(posedge clk); #1;
    mode = m; vec_len = len; base_0 = b0; base_1 = b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; en_cnt = 0;
    if (mem_en) begin en_cnt++; addr_log.push_back(int'(addr_0)); end
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (mem_en) begin en_cnt++; addr_log.push_back(int'(addr_0)); end
      if (res_valid) begin lat = e; break; end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    mode = 2'd0; vec_len = '0; base_0 = '0; base_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({mem_en, busy, res_valid, ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {mem_en, busy, res_valid, ovf}); end
    checks++; if (result !== 14'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if ({addr_0, addr_1} !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d exp 0/0", addr_0, addr_1); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(2'd2, 6'd9, 4'd0, 4'd0);
    checks++; if (lat !== 11) begin errors++; $display("FAIL add_latency got %0d exp 11", lat); end
    checks++; if (en_cnt !== 9) begin errors++; $display("FAIL add_mem_en_cycles got %0d exp 9", en_cnt); end
    checks++; if (result !== 14'd20) begin errors++; $display("FAIL add_result got %0d exp 20", result); end
    checks++; if ({ovf, busy} !== 2'b01) begin errors++; $display("FAIL add_ovf_busy got %b exp 01", {ovf, busy}); end
    checks++; if ({mem_en, addr_0} !== 5'd8) begin errors++; $display("FAIL add_addr_hold got en=%0d addr=%0d exp en=0 addr=8", mem_en, addr_0); end
    handshake();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_release got %b exp 00", {res_valid, busy}); end
  endtask

  task automatic test_mult();
    run_op(2'd1, 6'd9, 4'd0, 4'd0);
    checks++; if (result !== 14'd0 || lat !== 11) begin errors++; $display("FAIL mult_zero got res=%0d lat=%0d exp res=0 lat=11", result, lat); end
    handshake();
    for (int i = 0; i < 16; i++) mem1[i] = 4'd1;
    run_op(2'd1, 6'd9, 4'd0, 4'd0);
    checks++; if (result !== 14'd20) begin errors++; $display("FAIL mult_ones got %0d exp 20", result); end
    handshake();
    run_op(2'd2, 6'd9, 4'd0, 4'd0);
    checks++; if (result !== 14'd29) begin errors++; $display("FAIL add_ones got %0d exp 29", result); end
    handshake();
  endtask

  task automatic test_wrap();
    mem0[14] = 4'd7; mem0[15] = 4'd9;
    run_op(2'd3, 6'd4, 4'd14, 4'd0);
    checks++; if (addr_log.size() !== 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 14 || addr_log[1] !== 15 || addr_log[2] !== 0 || addr_log[3] !== 1) begin
        errors++; $display("FAIL wrap_addr got %0d,%0d,%0d,%0d exp 14,15,0,1", addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
      end
    end
    checks++; if (result !== 14'd20) begin errors++; $display("FAIL wrap_result got %0d exp 20", result); end
    handshake();
  endtask

  task automatic test_zero_len();
    run_op(2'd0, 6'd5, 4'd3, 4'd3);
    checks++; if (lat !== 2 || en_cnt !== 0) begin errors++; $display("FAIL clear_timing got lat=%0d en=%0d exp lat=2 en=0", lat, en_cnt); end
    checks++; if (result !== 14'd0) begin errors++; $display("FAIL clear_result got %0d exp 0", result); end
    checks++; if (addr_0 !== 4'd1) begin errors++; $display("FAIL clear_addr_hold got %0d exp 1", addr_0); end
    handshake();
    run_op(2'd2, 6'd0, 4'd0, 4'd0);
    checks++; if (lat !== 2 || en_cnt !== 0 || result !== 14'd0) begin errors++; $display("FAIL len0 got lat=%0d en=%0d res=%0d exp 2/0/0", lat, en_cnt, result); end
    handshake();
  endtask

  task automatic test_hold();
    run_op(2'd2, 6'd9, 4'd0, 4'd0);
    checks++; if (result !== 14'd29 || lat !== 11) begin errors++; $display("FAIL hold_initial got res=%0d lat=%0d exp 29/11", result, lat); end
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; mode = 2'd0; vec_len = 6'd0;
      @(posedge clk); #1;
      checks++; if (result !== 14'd29 || {res_valid, busy, mem_en} !== 3'b110) begin
        errors++; $display("FAIL hold_cycle%0d got res=%0d flags=%b exp 29/110", c, result, {res_valid, busy, mem_en});
      end
    end
    start = 1'b0;
    handshake();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL hold_release got %b exp 00", {res_valid, busy}); end
    @(posedge clk); #1;
    checks++; if ({busy, mem_en} !== 2'b00) begin errors++; $display("FAIL hold_no_restart got %b exp 00", {busy, mem_en}); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mode = 2'd2; vec_len = 6'd9; base_0 = 4'd2; base_1 = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, mem_en} !== 2'b11) begin errors++; $display("FAIL mid_running got %b exp 11", {busy, mem_en}); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++; if ({mem_en, busy, res_valid, ovf, addr_0, addr_1} !== 12'd0 || result !== 14'd0) begin
      errors++; $display("FAIL mid_reset got en=%0d busy=%0d rv=%0d ovf=%0d a0=%0d a1=%0d res=%0d exp all 0",
                         mem_en, busy, res_valid, ovf, addr_0, addr_1, result);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, mem_en} !== 2'b00) begin errors++; $display("FAIL mid_start_ignored got %b exp 00", {busy, mem_en}); end
  endtask

  task automatic test_overflow();
    for (int i = 8; i < 12; i++) mem0[i] = 4'd15;
    run_op(2'd3, 6'd4, 4'd8, 4'd0);
    checks++; if (result !== 14'd60 || ovf !== 1'b0) begin errors++; $display("FAIL wide_sum got res=%0d ovf=%0d exp 60/0", result, ovf); end
    checks++; if (s_ovf !== 1'b1 || s_res_valid !== 1'b1 || s_busy !== 1'b1) begin
      errors++; $display("FAIL narrow_ovf got ovf=%0d rv=%0d busy=%0d exp 1/1/1", s_ovf, s_res_valid, s_busy);
    end
`ifdef MAC_SEQ_SAT_EN
    checks++; if (s_result !== 4'd15) begin errors++; $display("FAIL narrow_result got %0d exp 15", s_result); end
`else
    checks++; if (s_result !== 4'd12) begin errors++; $display("FAIL narrow_result got %0d exp 12", s_result); end
`endif
    checks++; if (s_mem_en !== 1'b0 || s_addr_0 !== 4'd11 || s_addr_1 !== 4'd3) begin
      errors++; $display("FAIL narrow_addr got en=%0d a0=%0d a1=%0d exp 0/11/3", s_mem_en, s_addr_0, s_addr_1);
    end
    handshake();
    run_op(2'd3, 6'd1, 4'd0, 4'd0);
    checks++; if (s_ovf !== 1'b0 || s_result !== 4'd3) begin errors++; $display("FAIL ovf_clear got ovf=%0d res=%0d exp 0/3", s_ovf, s_result); end
    handshake();
  endtask

  initial begin
    logic [3:0] pat [9];
    pat = '{4'd3, 4'd1, 4'd2, 4'd6, 4'd0, 4'd5, 4'd0, 4'd0, 4'd3};
    for (int i = 0; i < 16; i++) begin mem0[i] = '0; mem1[i] = '0; end
    for (int i = 0; i < 9; i++) mem0[i] = pat[i];
    test_reset();
    test_add();
    test_mult();
    test_wrap();
    test_zero_len();
    test_hold();
    test_reset_mid();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1);
  end

endmodule
